// File: rtl/fp_result_drain_pkg.sv
// Shared sizing and FSM state encoding for the filter-pipeline result drain.
package fp_pkg;

    localparam int BIT_VEC_SIZE     = 128;
    localparam int BIT_VEC_SIZE_LOG = 7;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/fp_result_drain_if.sv
// Vector-in / ID-out handshake bundle for one drain lane.
// FP_DRAIN_EMPTY_MARK_EN adds the id_empty flag to the ID stream.
interface fp_result_drain_if #(
    parameter int BIT_VEC_SIZE     = fp_pkg::BIT_VEC_SIZE,
    parameter int BIT_VEC_SIZE_LOG = fp_pkg::BIT_VEC_SIZE_LOG
);
    logic [BIT_VEC_SIZE-1:0]     vec_in;
    logic                        vec_valid;
    logic                        vec_ready;
    logic [BIT_VEC_SIZE_LOG-1:0] id_out;
    logic                        id_valid;
    logic                        id_ready;
    logic                        id_last;
`ifdef FP_DRAIN_EMPTY_MARK_EN
    logic                        id_empty;

    modport master (
        output vec_in, vec_valid, id_ready,
        input  vec_ready, id_out, id_valid, id_last, id_empty
    );

    modport slave (
        input  vec_in, vec_valid, id_ready,
        output vec_ready, id_out, id_valid, id_last, id_empty
    );
`else
    modport master (
        output vec_in, vec_valid, id_ready,
        input  vec_ready, id_out, id_valid, id_last
    );

    modport slave (
        input  vec_in, vec_valid, id_ready,
        output vec_ready, id_out, id_valid, id_last
    );
`endif
endinterface

// File: rtl/fp_result_drain_ffs.sv
// Combinational lowest-set-bit finder with zero and one-hot detection.
module fp_ffs #(
    parameter int BIT_VEC_SIZE     = fp_pkg::BIT_VEC_SIZE,
    parameter int BIT_VEC_SIZE_LOG = fp_pkg::BIT_VEC_SIZE_LOG
) (
    input  logic [BIT_VEC_SIZE-1:0]     vec,
    output logic [BIT_VEC_SIZE_LOG-1:0] idx,
    output logic                        any,
    output logic                        single
);
    logic [BIT_VEC_SIZE-1:0] vec_minus_one;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = BIT_VEC_SIZE - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = BIT_VEC_SIZE_LOG'(i);
            end
        end
    end

    assign vec_minus_one = vec - BIT_VEC_SIZE'(1);
    assign any           = |vec;
    assign single        = any && ((vec & vec_minus_one) == '0);

endmodule

// File: rtl/fp_result_drain.sv
// Drains one filter-pipeline result vector as a stream of ascending record IDs.
// FP_DRAIN_EMPTY_MARK_EN: an all-zero vector emits a single id_empty marker beat.
//
//   state | meaning
//   IDLE  | ready for a new result vector, no ID beat offered
//   DRAIN | emitting the lowest remaining set bit of work_vec each beat
module fp_result_drain #(
    parameter int BIT_VEC_SIZE     = fp_pkg::BIT_VEC_SIZE,
    parameter int BIT_VEC_SIZE_LOG = fp_pkg::BIT_VEC_SIZE_LOG
) (
    input  logic                clk,
    input  logic                rst,
    fp_result_drain_if.slave    bus,
    output logic [15:0]         vec_done_cnt
);
    import fp_pkg::*;

    drain_state_e                state_q, state_d;
    logic [BIT_VEC_SIZE-1:0]     work_vec_q, work_vec_d;
    logic [15:0]                 done_cnt_q, done_cnt_d;
    logic [BIT_VEC_SIZE_LOG-1:0] ffs_idx;
    logic                        ffs_any;
    logic                        ffs_single;
    logic                        in_drain;
    logic                        beat_last;

    fp_ffs #(
        .BIT_VEC_SIZE     (BIT_VEC_SIZE),
        .BIT_VEC_SIZE_LOG (BIT_VEC_SIZE_LOG)
    ) u_ffs (
        .vec    (work_vec_q),
        .idx    (ffs_idx),
        .any    (ffs_any),
        .single (ffs_single)
    );

    // An empty work vector in DRAIN only arises from the empty-marker beat.
    assign in_drain  = (state_q == DRAIN) && !rst;
    assign beat_last = ffs_single || !ffs_any;

    assign bus.vec_ready = (state_q == IDLE) && !rst;
    assign bus.id_valid  = in_drain;
    assign bus.id_out    = in_drain ? ffs_idx : '0;
    assign bus.id_last   = in_drain && beat_last;
`ifdef FP_DRAIN_EMPTY_MARK_EN
    assign bus.id_empty  = in_drain && !ffs_any;
`endif
    assign vec_done_cnt  = done_cnt_q;

    always_comb begin
        state_d    = state_q;
        work_vec_d = work_vec_q;
        done_cnt_d = done_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.vec_valid && bus.vec_ready) begin
                    work_vec_d = bus.vec_in;
`ifdef FP_DRAIN_EMPTY_MARK_EN
                    state_d = DRAIN;
`else
                    if (|bus.vec_in) begin
                        state_d = DRAIN;
                    end else begin
                        done_cnt_d = sat_inc16(done_cnt_q);
                    end
`endif
                end
            end
            DRAIN: begin
                if (bus.id_valid && bus.id_ready) begin
                    // x & (x-1) clears exactly the lowest set bit.
                    work_vec_d = work_vec_q & (work_vec_q - BIT_VEC_SIZE'(1));
                    if (beat_last) begin
                        state_d    = IDLE;
                        done_cnt_d = sat_inc16(done_cnt_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            work_vec_q <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            work_vec_q <= work_vec_d;
            done_cnt_q <= done_cnt_d;
        end
    end

endmodule

// File: tb/tb_fp_result_drain.sv
// Self-checking bench for fp_result_drain: directed table, corner sequences,
// randomized vectors against a set-bit-list reference model, counter saturation.
module tb_fp_result_drain;
    import fp_pkg::*;

    localparam int W = BIT_VEC_SIZE;
    typedef logic [W-1:0] vec_t;

    typedef struct {
        vec_t v;
        int   beats;
        int   first;
        int   last;
    } tv_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] vec_done_cnt;

    fp_result_drain_if bus ();

    fp_result_drain dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .vec_done_cnt (vec_done_cnt)
    );

    always #5 clk = ~clk;

    int n_vec   = 0;
    int n_err   = 0;
    int exp_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t bit_at(input int k);
        vec_t one;
        one = vec_t'(1);
        return one << k;
    endfunction

    // Precondition: at a negedge, DUT idle, v already driven with vec_valid=1.
    // mode 0: id_ready always 1; mode 1: 1,0,1,0...; mode 2: random.
    task automatic run_vec(input vec_t v, input int mode, input bit chain, input vec_t nxt,
                           output int nbeats, output int first_id, output int last_id);
        int q[$];
        int cyc;
        bit rdy;
        bit tgl;
        nbeats   = 0;
        first_id = -1;
        last_id  = -1;
        tgl      = 1'b1;
        for (int k = 0; k < W; k++) begin
            if (v[k]) q.push_back(k);
        end
`ifdef FP_DRAIN_EMPTY_MARK_EN
        if (q.size() == 0) q.push_back(0);
`endif
        check("vec_ready_idle", bus.vec_ready, 1);
        @(negedge clk);
        if (chain) bus.vec_in = nxt;
        else bus.vec_valid = 1'b0;
        cyc = 0;
        while (q.size() > 0 && cyc < 400) begin
            check("id_valid", bus.id_valid, 1);
            check("vec_ready_drain", bus.vec_ready, 0);
            check("id_out", bus.id_out, q[0]);
            check("id_last", bus.id_last, q.size() == 1);
`ifdef FP_DRAIN_EMPTY_MARK_EN
            check("id_empty", bus.id_empty, v == '0);
`endif
            case (mode)
                0:       rdy = 1'b1;
                1:       begin rdy = tgl; tgl = ~tgl; end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.id_ready = rdy;
            if (bus.id_valid && rdy) begin
                if (nbeats == 0) first_id = int'(bus.id_out);
                if (bus.id_last) last_id = int'(bus.id_out);
                nbeats++;
                void'(q.pop_front());
            end
            cyc++;
            @(negedge clk);
        end
        if (q.size() > 0) check("drain_timeout", q.size(), 0);
        exp_cnt = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
        check("id_valid_after", bus.id_valid, 0);
        check("vec_ready_after", bus.vec_ready, 1);
        check("vec_done_cnt", vec_done_cnt, exp_cnt);
    endtask

    task automatic present(input vec_t v);
        @(negedge clk);
        bus.vec_in    = v;
        bus.vec_valid = 1'b1;
    endtask

    tv_t  tbl[7];
    vec_t v3;
    vec_t rv;
    int   nb, fi, la, sel, pre_cyc;

    initial begin
        bus.vec_in    = '0;
        bus.vec_valid = 1'b0;
        bus.id_ready  = 1'b1;
        v3 = bit_at(3) | bit_at(5) | bit_at(127);

        tbl[0] = '{v3,                       3,   3, 127};
        tbl[1] = '{bit_at(0),                1,   0,   0};
        tbl[2] = '{bit_at(127),              1, 127, 127};
        tbl[3] = '{bit_at(0) | bit_at(127),  2,   0, 127};
        tbl[4] = '{vec_t'(128'hF0),          4,   4,   7};
        tbl[5] = '{'1,                     128,   0, 127};
`ifdef FP_DRAIN_EMPTY_MARK_EN
        tbl[6] = '{'0,                       1,   0,   0};
`else
        tbl[6] = '{'0,                       0,  -1,  -1};
`endif

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_vec_ready", bus.vec_ready, 0);
        check("rst_id_valid", bus.id_valid, 0);
        check("rst_id_last", bus.id_last, 0);
        check("rst_id_out", bus.id_out, 0);
        check("rst_cnt", vec_done_cnt, 0);
        rst = 1'b0;
        #1;
        check("post_rst_vec_ready", bus.vec_ready, 1);

        // Directed table, id_ready held high
        for (int i = 0; i < 7; i++) begin
            present(tbl[i].v);
            run_vec(tbl[i].v, 0, 1'b0, '0, nb, fi, la);
            check($sformatf("tbl%0d_beats", i), nb, tbl[i].beats);
            check($sformatf("tbl%0d_first", i), fi, tbl[i].first);
            check($sformatf("tbl%0d_last", i), la, tbl[i].last);
        end

        // Stalling consumer
        present(v3);
        run_vec(v3, 1, 1'b0, '0, nb, fi, la);
        check("stall_beats", nb, 3);
        check("stall_last", la, 127);

        // Second vector held pending during a full drain
        present('1);
        run_vec('1, 0, 1'b1, v3, nb, fi, la);
        check("chain_all_beats", nb, 128);
        run_vec(v3, 0, 1'b0, '0, nb, fi, la);
        check("chain_next_beats", nb, 3);
        check("chain_next_first", fi, 3);

        // Reset mid-drain after two of five beats
        rv = bit_at(1) | bit_at(9) | bit_at(20) | bit_at(40) | bit_at(100);
        present(rv);
        bus.id_ready = 1'b1;
        @(negedge clk);
        bus.vec_valid = 1'b0;
        check("mid_beat0", bus.id_out, 1);
        @(negedge clk);
        check("mid_beat1", bus.id_out, 9);
        @(negedge clk);
        check("mid_beat2_offered", bus.id_out, 20);
        rst = 1'b1;
        #1;
        check("mid_rst_id_valid", bus.id_valid, 0);
        check("mid_rst_vec_ready", bus.vec_ready, 0);
        check("mid_rst_id_out", bus.id_out, 0);
        check("mid_rst_id_last", bus.id_last, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        check("mid_after_id_valid", bus.id_valid, 0);
        check("mid_after_vec_ready", bus.vec_ready, 1);
        check("mid_after_cnt", vec_done_cnt, 0);
        @(negedge clk);
        check("mid_no_beat", bus.id_valid, 0);
        rv = bit_at(2) | bit_at(7);
        present(rv);
        run_vec(rv, 0, 1'b0, '0, nb, fi, la);
        check("mid_next_first", fi, 2);
        check("mid_next_beats", nb, 2);

        // Randomized vectors with random back-pressure
        for (int n = 0; n < 40; n++) begin
            for (int w = 0; w < W / 32; w++) begin
                rv[32*w +: 32] = $urandom() & $urandom() & $urandom();
            end
            sel = int'($urandom_range(0, 9));
            if (sel == 0) rv = '0;
            else if (sel == 1) rv = bit_at(int'($urandom_range(0, W - 1)));
            present(rv);
            run_vec(rv, 2, 1'b0, '0, nb, fi, la);
            check($sformatf("rand%0d_beats", n), nb,
`ifdef FP_DRAIN_EMPTY_MARK_EN
                  (rv == '0) ? 1 : $countones(rv));
`else
                  $countones(rv));
`endif
        end

        // Counter saturation: preload 65535 empty vectors, then one more real one
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
`ifdef FP_DRAIN_EMPTY_MARK_EN
        pre_cyc = 2 * 65535;
`else
        pre_cyc = 65535;
`endif
        bus.id_ready  = 1'b1;
        bus.vec_in    = '0;
        bus.vec_valid = 1'b1;
        repeat (pre_cyc) @(posedge clk);
        @(negedge clk);
        bus.vec_valid = 1'b0;
        exp_cnt = 65535;
        check("sat_preload_cnt", vec_done_cnt, exp_cnt);
        present(v3);
        run_vec(v3, 0, 1'b0, '0, nb, fi, la);
        check("sat_beats", nb, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #6000000;
        $display("FAIL watchdog: time limit reached after %0d vectors", n_vec);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp_result_drain.md
FP_RESULT_DRAIN -- requirements
Module: fp_result_drain

Interface
REQ-001 Parameter BIT_VEC_SIZE, default 128, width of one filter-pipeline result bit vector; bit k set means record ID k passed all stages.
REQ-002 Parameter BIT_VEC_SIZE_LOG, default 7, width of a record ID; equals clog2(BIT_VEC_SIZE).
REQ-003 clk  input  1  single clock; every state element updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 vec_in  input  BIT_VEC_SIZE  result vector from one pipeline output lane.
REQ-006 vec_valid  input  1  vec_in holds a result vector.
REQ-007 vec_ready  output  1  block accepts vec_in this cycle.
REQ-008 id_out  output  BIT_VEC_SIZE_LOG  index of one set bit of the vector being drained.
REQ-009 id_valid  output  1  id_out holds a valid beat.
REQ-010 id_ready  input  1  downstream accepts the beat.
REQ-011 id_last  output  1  this beat is the final beat of the current vector.
REQ-012 vec_done_cnt  output  16  number of vectors fully drained; saturates at 16'hFFFF.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and DRAIN.
REQ-014 In IDLE: vec_ready=1 and id_valid=0.
REQ-015 In DRAIN: vec_ready=0; a vector offered while vec_valid=1 in DRAIN SHALL NOT be accepted and SHALL remain pending.
REQ-016 Handshake: a vector transfers when vec_valid&&vec_ready at a rising edge; it is captured into the working register work_vec.
REQ-017 A non-zero captured vector SHALL move the FSM to DRAIN; the first id_valid appears the cycle after capture (latency 1).
REQ-018 In DRAIN: id_out SHALL equal the index of the lowest set bit of work_vec; id_valid=1.
REQ-019 In DRAIN: id_last=1 exactly when work_vec has one set bit.
REQ-020 Beat transfer: id_valid&&id_ready at an edge clears that bit in work_vec.
REQ-021 id_out, id_valid and id_last SHALL stay stable while id_valid=1 and id_ready=0.
REQ-022 IDs SHALL be emitted in strictly ascending order, one per accepted beat, with no gaps and no duplicates.
REQ-023 On transfer of the id_last beat: return to IDLE; increment vec_done_cnt unless it is already saturated.
REQ-024 All-zero vector: behaviour is set by REQ-029/REQ-030.
REQ-025 Sustained throughput in DRAIN SHALL be one ID per cycle while id_ready=1.

Reset
REQ-026 While rst=1 at an edge: state=IDLE, work_vec=0, vec_done_cnt=0.
REQ-027 During reset: id_valid=0, id_last=0, id_out=0, vec_ready=0.
REQ-028 Reset asserted mid-DRAIN SHALL discard the remaining bits; no further beat is emitted for that vector.

Configuration
REQ-029 With FP_DRAIN_EMPTY_MARK_EN defined: an all-zero vector enters DRAIN and emits one beat with id_out=0, id_valid=1, id_last=1.
REQ-029a That beat is flagged on the extra output id_empty (1 bit); id_empty=0 on every other beat. The vector counts in vec_done_cnt.
REQ-030 Without FP_DRAIN_EMPTY_MARK_EN: an all-zero vector is consumed in IDLE, FSM stays IDLE, no beat is emitted, and vec_done_cnt increments. The id_empty port is absent.

Structure
REQ-031 BIT_VEC_SIZE, BIT_VEC_SIZE_LOG and the state enum (IDLE, DRAIN) SHALL live in the shared package fp_pkg.
REQ-032 Lowest-set-bit search SHALL be in the combinational sub-module fp_ffs.
REQ-032a fp_ffs ports: vec in, idx out, any out (any=1 when vec is non-zero), single out (single=1 when vec has exactly one set bit).
REQ-033 One fp_result_drain instance per filter-pipeline output lane.

Verification
REQ-034 Vector with bits {3,5,127}, id_ready=1 -> ids 3,5,127 on consecutive cycles starting one cycle after capture; id_last only on 127; vec_done_cnt=1.
REQ-035 Same vector, id_ready toggling 1,0,1,0 -> outputs held stable while stalled; same sequence emitted; vec_ready=0 throughout DRAIN.
REQ-036 All-ones vector -> 128 beats, ids 0..127, id_last on 127; a second vector held with vec_valid=1 is accepted only after the return to IDLE.
REQ-037 All-zero vector -> with macro: one beat, id_empty=1, id_last=1; without macro: no beat. vec_done_cnt=1 in both builds.
REQ-038 rst=1 after 2 of 5 beats -> next cycle id_valid=0, state=IDLE, vec_done_cnt=0; the next vector drains correctly from its lowest set bit.
REQ-039 Preload 65535 drained vectors, then drain one more -> vec_done_cnt stays 16'hFFFF.
